alu_operand_sequencer: RTL
==========================

Name: alu_operand_sequencer

Overview:
Front-end controller that produces the operand and operation inputs for the lab ALU from board switches and two push buttons. It debounces both buttons and steps an FSM through loading A, loading B and loading the operation code. It then issues one execute strobe and latches the ALU status flags for display. It sits between the board I/O pins and the combinational ALU, and drives the ALU's a/b/operation inputs from registers.

Parameters:
N, 4, operand width in bits; must match the ALU's N.
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a button level change is accepted; synthesis top overrides this, e.g. 500000.
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sw  in  N  operand switches, asynchronous to clk
op_sw  in  4  operation-code switches, asynchronous to clk
btn_next  in  1  raw push button, active-high, bouncing
btn_clear  in  1  raw push button, active-high, bouncing
alu_carry  in  1  ALU carryOutF
alu_overflow  in  1  ALU overflowF
alu_negative  in  1  ALU negativeF
alu_zero  in  1  ALU zeroF
a  out  N  registered operand A to ALU
b  out  N  registered operand B to ALU
operation  out  4  registered ALU op code
exec_valid  out  1  one-cycle strobe; a/b/operation are complete and stable
stage  out  3  FSM state code, used for LED indication
flags  out  4  latched {carry, overflow, negative, zero}

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - All state updates on the rising edge of clk. rst is sampled there and has priority over everything.
- Reset values:
  - a=0, b=0, operation=4'b1111 (the ALU's clear code), exec_valid=0, stage=0, flags=0.
  - Sync flops, stable levels and debounce counters all 0. FSM in LOAD_A.
- Synchronisers:
  - sw, op_sw, btn_next and btn_clear each pass through a 2-flop synchroniser.
  - All captures use the synchronised values.
- Debounce, per button:
  - The counter increments each cycle that the synced value differs from the stable level. It clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level toggles and the counter clears.
  - press is a registered one-cycle pulse on the stable level's 0->1 transition. Release generates no pulse.
  - Latency: a raw level held high from edge k produces press high in the cycle after edge k+DEBOUNCE_CYCLES+2.
  - Any bounce shorter than DEBOUNCE_CYCLES produces no press and no level change.
  - A button held through reset release yields exactly one press, after the normal latency.
- FSM states (stage encoding): LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4. Codes 5-7 are illegal and recover to LOAD_A.
  - LOAD_A + next_press: a<=sw_sync, go to LOAD_B.
  - LOAD_B + next_press: b<=sw_sync, go to LOAD_OP.
  - LOAD_OP + next_press: operation<=op_sw_sync, go to EXEC.
  - EXEC: lasts exactly 1 cycle with exec_valid=1. flags<={alu_carry, alu_overflow, alu_negative, alu_zero} are latched at the end of this cycle. Unconditionally go to SHOW. Any next_press during EXEC is ignored.
  - SHOW + next_press: go to LOAD_A. a, b and operation hold their values until overwritten.
- Clear: clear_press in any state forces the following:
  - a=0, b=0, operation=4'b1111, flags=0, exec_valid=0.
  - FSM goes to LOAD_A on the next edge.
  - Clear wins over a simultaneous next_press.
- Hold behaviour:
  - exec_valid is never high for two consecutive cycles.
  - a, b, operation and flags change only on the events listed above.
- Reset mid-sequence: any captured operands are discarded and all reset values are restored.

Test Plan:
1. Reset, DEBOUNCE_CYCLES=4. Raw btn_next high for 20 cycles -> exactly one press; stage 0->1 exactly 7 cycles after the first sampling edge; a=sw.
2. Sequence sw=3 press, sw=5 press, op_sw=0110 press -> a=3, b=5, operation=0110; exec_valid high for 1 cycle; stage=4; with alu_zero=0 and alu_carry=0 driven, flags=4'b0000.
3. btn_next bounce of 3 high, 1 low, 2 high cycles, then low -> no press; stage unchanged, counter back to 0.
4. In LOAD_OP with a=7, b=2, clear and next debounced on the same cycle -> a=0, b=0, operation=1111, stage=0, no exec_valid.
5. Sequence completes with alu_zero=1 and alu_negative=1 -> flags=4'b0011 held through SHOW. A further press -> stage=0 while a, b and flags stay unchanged.
6. Assert rst while in LOAD_B with a=9 -> next edge: all reset values; a subsequent press loads A afresh.

Source files
------------

// File: rtl/alu_operand_sequencer_if.sv
// ============================================================================
// Module   : alu_operand_sequencer_if
// Brief    : Board-I/O and ALU-side signal bundle for the operand sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_operand_sequencer_if #(
    parameter int N = 4
);
    logic [N-1:0] sw;
    logic [3:0]   op_sw;
    logic         btn_next;
    logic         btn_clear;
    logic         alu_carry;
    logic         alu_overflow;
    logic         alu_negative;
    logic         alu_zero;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   operation;
    logic         exec_valid;
    logic [2:0]   stage;
    logic [3:0]   flags;

    modport master (
        input  sw, op_sw, btn_next, btn_clear,
        input  alu_carry, alu_overflow, alu_negative, alu_zero,
        output a, b, operation, exec_valid, stage, flags
    );

    modport slave (
        output sw, op_sw, btn_next, btn_clear,
        output alu_carry, alu_overflow, alu_negative, alu_zero,
        input  a, b, operation, exec_valid, stage, flags
    );
endinterface

`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
// ============================================================================
// Module   : alu_operand_sequencer
// Brief    : Debounced two-button front-end that loads ALU operands/op code.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_operand_sequencer #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  wire logic               clk,
    input  wire logic               rst,
    alu_operand_sequencer_if.master bus
);

    localparam logic [3:0]       C_OP_CLEAR = 4'b1111;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    logic [N-1:0] sw_meta_q, sw_sync_q;
    logic [3:0]   op_meta_q, op_sync_q;
    logic [1:0]   w_btn_raw;
    logic [1:0]   w_press;
    logic         w_next_press;
    logic         w_clear_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            op_meta_q <= '0;
            op_sync_q <= '0;
        end else begin
            sw_meta_q <= bus.sw;
            sw_sync_q <= sw_meta_q;
            op_meta_q <= bus.op_sw;
            op_sync_q <= op_meta_q;
        end
    end

    assign w_btn_raw     = {bus.btn_clear, bus.btn_next};
    assign w_next_press  = w_press[0];
    assign w_clear_press = w_press[1];

    // Toggling on the cycle the count would hit DEBOUNCE_CYCLES keeps the
    // press pulse at DEBOUNCE_CYCLES+2 edges after the raw level first lands.
    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic             meta_q, sync_q;
        logic             stable_q, stable_d, stable_prev_q;
        logic             press_q, press_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            stable_d = stable_q;
            cnt_d    = '0;
            if (sync_q != stable_q) begin
                if (cnt_q == C_CNT_LAST) begin
                    stable_d = ~stable_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            press_d = stable_q & ~stable_prev_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                meta_q        <= 1'b0;
                sync_q        <= 1'b0;
                stable_q      <= 1'b0;
                stable_prev_q <= 1'b0;
                press_q       <= 1'b0;
                cnt_q         <= '0;
            end else begin
                meta_q        <= w_btn_raw[g];
                sync_q        <= meta_q;
                stable_q      <= stable_d;
                stable_prev_q <= stable_q;
                press_q       <= press_d;
                cnt_q         <= cnt_d;
            end
        end

        assign w_press[g] = press_q;
    end

    state_t       state_q, state_d;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]   op_q, op_d, flags_q, flags_d;
    logic         exec_valid_q, exec_valid_d;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        flags_d      = flags_q;
        exec_valid_d = 1'b0;
        if (w_clear_press) begin
            a_d     = '0;
            b_d     = '0;
            op_d    = C_OP_CLEAR;
            flags_d = '0;
            state_d = LOAD_A;
        end else begin
            case (state_q)
                LOAD_A: if (w_next_press) begin
                    a_d     = sw_sync_q;
                    state_d = LOAD_B;
                end
                LOAD_B: if (w_next_press) begin
                    b_d     = sw_sync_q;
                    state_d = LOAD_OP;
                end
                LOAD_OP: if (w_next_press) begin
                    op_d         = op_sync_q;
                    exec_valid_d = 1'b1;
                    state_d      = EXEC;
                end
                EXEC: begin
                    flags_d = {bus.alu_carry, bus.alu_overflow,
                               bus.alu_negative, bus.alu_zero};
                    state_d = SHOW;
                end
                SHOW: if (w_next_press) begin
                    state_d = LOAD_A;
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD_A;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= C_OP_CLEAR;
            flags_q      <= '0;
            exec_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            flags_q      <= flags_d;
            exec_valid_q <= exec_valid_d;
        end
    end

    assign bus.a          = a_q;
    assign bus.b          = b_q;
    assign bus.operation  = op_q;
    assign bus.flags      = flags_q;
    assign bus.exec_valid = exec_valid_q;
    assign bus.stage      = state_q;

endmodule

`default_nettype wire
